// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: display fetch, CPU port, scroll/fill control and the RAM port.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  logic                  disp_req;
  logic [4:0]            disp_row;
  logic [6:0]            disp_col;
  logic                  disp_valid;
  logic [DATA_WIDTH-1:0] disp_data;

  logic                  cpu_valid;
  logic                  cpu_ready;
  logic                  cpu_we;
  logic [4:0]            cpu_row;
  logic [6:0]            cpu_col;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  logic                  scroll_inc;
  logic [4:0]            scroll_row;
  logic                  fill_start;
  logic [4:0]            fill_row;
  logic                  fill_busy;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  disp_req, disp_row, disp_col,
    input  cpu_valid, cpu_we, cpu_row, cpu_col, cpu_wdata,
    input  scroll_inc, fill_start, fill_row, ram_rdata,
    output disp_valid, disp_data, cpu_ready, cpu_rvalid, cpu_rdata,
    output scroll_row, fill_busy, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output disp_req, disp_row, disp_col,
    output cpu_valid, cpu_we, cpu_row, cpu_col, cpu_wdata,
    output scroll_inc, fill_start, fill_row, ram_rdata,
    input  disp_valid, disp_data, cpu_ready, cpu_rvalid, cpu_rdata,
    input  scroll_row, fill_busy, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port text VRAM scheduler (display > fill > CPU) with hardware scroll mapping.
// Define VRAM_FILL_EN to build the row-fill engine and fill-on-scroll behaviour.
module vram_arbiter #(
  parameter int                    COLUMNS    = 80,
  parameter int                    ROWS       = 24,
  parameter int                    ADDR_WIDTH = 11,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] FILL_CHAR  = 8'h20
) (
  input logic          clk,
  input logic          reset_n,
  vram_arbiter_if.slave bus
);

  logic [4:0] scroll_q;
  logic       scroll_acc;
  logic       fill_busy;
  logic       vld_p1;
  logic       disp_oor_p1;
  logic       cpu_rvld_p1;
  logic       cpu_oor_p1;

  function automatic logic is_oor(input logic [4:0] row, input logic [6:0] col);
    return (int'(row) >= ROWS) || (int'(col) >= COLUMNS);
  endfunction

  // Logical row -> physical row via the scroll offset (single conditional subtract).
  function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [4:0] row,
                                                     input logic [6:0] col,
                                                     input logic [4:0] scr);
    logic [5:0]  sum;
    logic [31:0] full;
    sum = {1'b0, row} + {1'b0, scr};
    if (sum >= 6'(ROWS)) sum = sum - 6'(ROWS);
    full = 32'(sum) * 32'(COLUMNS) + 32'(col);
    return full[ADDR_WIDTH-1:0];
  endfunction

`ifdef VRAM_FILL_EN
  typedef enum logic {IDLE, FILL} fill_state_t;

  fill_state_t state_q, state_d;
  logic [4:0]  fill_row_q, fill_row_d;
  logic [6:0]  fill_col_q, fill_col_d;

  assign fill_busy  = (state_q == FILL);
  assign scroll_acc = bus.scroll_inc & ~fill_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fill_row_q <= '0;
      fill_col_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_row_q <= fill_row_d;
      fill_col_q <= fill_col_d;
    end
  end

  // A scroll exposes a stale bottom line, so its fill takes precedence over fill_start.
  always_comb begin
    state_d    = state_q;
    fill_row_d = fill_row_q;
    fill_col_d = fill_col_q;
    case (state_q)
      IDLE: begin
        if (scroll_acc) begin
          state_d    = FILL;
          fill_row_d = 5'(ROWS - 1);
          fill_col_d = '0;
        end else if (bus.fill_start && (int'(bus.fill_row) < ROWS)) begin
          state_d    = FILL;
          fill_row_d = bus.fill_row;
          fill_col_d = '0;
        end
      end
      FILL: begin
        if (!bus.disp_req) begin
          if (fill_col_q == 7'(COLUMNS - 1)) state_d = IDLE;
          else fill_col_d = fill_col_q + 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
`else
  assign fill_busy  = 1'b0;
  assign scroll_acc = bus.scroll_inc;
`endif

  // Stage p0: combinational port selection.
  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    bus.cpu_ready = 1'b0;
    if (bus.disp_req) begin
      bus.ram_addr = map_addr(bus.disp_row, bus.disp_col, scroll_q);
    end else if (fill_busy) begin
`ifdef VRAM_FILL_EN
      bus.ram_addr  = map_addr(fill_row_q, fill_col_q, scroll_q);
      bus.ram_we    = 1'b1;
      bus.ram_wdata = FILL_CHAR;
`endif
    end else if (bus.cpu_valid) begin
      bus.cpu_ready = 1'b1;
      bus.ram_addr  = map_addr(bus.cpu_row, bus.cpu_col, scroll_q);
      bus.ram_we    = bus.cpu_we & ~is_oor(bus.cpu_row, bus.cpu_col);
      bus.ram_wdata = bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scroll_q    <= '0;
      vld_p1      <= 1'b0;
      disp_oor_p1 <= 1'b0;
      cpu_rvld_p1 <= 1'b0;
      cpu_oor_p1  <= 1'b0;
    end else begin
      vld_p1      <= bus.disp_req;
      disp_oor_p1 <= is_oor(bus.disp_row, bus.disp_col);
      cpu_rvld_p1 <= bus.cpu_ready & ~bus.cpu_we;
      cpu_oor_p1  <= is_oor(bus.cpu_row, bus.cpu_col);
      if (scroll_acc)
        scroll_q <= (scroll_q == 5'(ROWS - 1)) ? 5'd0 : scroll_q + 5'd1;
    end
  end

  // Stage p1: RAM read data returns; out-of-range results are substituted here.
  assign bus.disp_valid = vld_p1;
  assign bus.disp_data  = vld_p1 ? (disp_oor_p1 ? FILL_CHAR : bus.ram_rdata) : '0;
  assign bus.cpu_rvalid = cpu_rvld_p1;
  assign bus.cpu_rdata  = cpu_rvld_p1 ? (cpu_oor_p1 ? '0 : bus.ram_rdata) : '0;
  assign bus.scroll_row = scroll_q;
  assign bus.fill_busy  = fill_busy;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: screen-level reference model, randomized and directed stimulus.
module tb_vram_arbiter;
  localparam int COLUMNS = 80;
  localparam int ROWS    = 24;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if bus ();
  vram_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct {
    bit         dreq;
    logic [4:0] drow;
    logic [6:0] dcol;
    bit         cv;
    bit         cwe;
    logic [4:0] crow;
    logic [6:0] ccol;
    logic [7:0] cwd;
    bit         sinc;
    bit         fstart;
    logic [4:0] frow;
  } stim_t;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t disp_q[$];
  exp_t cpu_q[$];
  exp_t e_mon;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: screen indexed by physical row, scroll offset, fill progress.
  logic [7:0] screen [0:ROWS-1][0:COLUMNS-1];
  int m_scroll = 0;
  bit m_busy = 0;
  int m_frow = 0;
  int m_fcol = 0;
  bit last_ready, smp_busy, smp_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int phys(input int row);
    return (row + m_scroll) % ROWS;
  endfunction

  function automatic bit oor(input int r, input int c);
    return (r >= ROWS) || (c >= COLUMNS);
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.disp_req   = s.dreq;  bus.disp_row = s.drow; bus.disp_col = s.dcol;
    bus.cpu_valid  = s.cv;    bus.cpu_we   = s.cwe;  bus.cpu_row  = s.crow;
    bus.cpu_col    = s.ccol;  bus.cpu_wdata = s.cwd;
    bus.scroll_inc = s.sinc;  bus.fill_start = s.fstart; bus.fill_row = s.frow;
  endtask

  // One clock: drive at posedge+1, check and advance the model at negedge.
  task automatic step(input stim_t s);
    bit   busy_old, rdy;
    int   pr;
    exp_t x;
    drive(s);
    @(negedge clk);
    busy_old   = m_busy;
    rdy        = s.cv && !s.dreq && !busy_old;
    last_ready = rdy;
    smp_busy   = bus.fill_busy;
    smp_we     = bus.ram_we;
    chk("cpu_ready", bus.cpu_ready, rdy);
    chk("fill_busy", bus.fill_busy, busy_old);
    chk("scroll_row", bus.scroll_row, m_scroll);
    if (s.dreq) begin
      chk("disp_ram_we", bus.ram_we, 0);
      if (oor(s.drow, s.dcol)) x.data = 8'h20;
      else begin
        chk("disp_addr", bus.ram_addr, phys(s.drow) * COLUMNS + s.dcol);
        x.data = screen[phys(s.drow)][s.dcol];
      end
      x.due = cyc + 1;
      disp_q.push_back(x);
    end else if (busy_old) begin
      pr = phys(m_frow);
      chk("fill_we", bus.ram_we, 1);
      chk("fill_addr", bus.ram_addr, pr * COLUMNS + m_fcol);
      chk("fill_wdata", bus.ram_wdata, 8'h20);
      screen[pr][m_fcol] = 8'h20;
      m_fcol++;
      if (m_fcol == COLUMNS) m_busy = 0;
    end else if (s.cv) begin
      x.due = cyc + 1;
      if (oor(s.crow, s.ccol)) begin
        chk("cpu_oor_we", bus.ram_we, 0);
        x.data = 8'h00;
        if (!s.cwe) cpu_q.push_back(x);
      end else begin
        chk("cpu_addr", bus.ram_addr, phys(s.crow) * COLUMNS + s.ccol);
        chk("cpu_we", bus.ram_we, s.cwe);
        if (s.cwe) begin
          chk("cpu_wdata", bus.ram_wdata, s.cwd);
          screen[phys(s.crow)][s.ccol] = s.cwd;
        end else begin
          x.data = screen[phys(s.crow)][s.ccol];
          cpu_q.push_back(x);
        end
      end
    end else begin
      chk("idle_we", bus.ram_we, 0);
    end
    if (s.sinc && !busy_old) begin
      m_scroll = (m_scroll + 1) % ROWS;
`ifdef VRAM_FILL_EN
      m_busy = 1; m_frow = ROWS - 1; m_fcol = 0;
`endif
    end
`ifdef VRAM_FILL_EN
    else if (s.fstart && !busy_old && s.frow < ROWS) begin
      m_busy = 1; m_frow = s.frow; m_fcol = 0;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(idle_stim());
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_scroll = 0; m_busy = 0;
    chk("rst_scroll_row", bus.scroll_row, 0);
    chk("rst_fill_busy", bus.fill_busy, 0);
    chk("rst_disp_valid", bus.disp_valid, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_disp_data", bus.disp_data, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    reset_n = 1'b1;
  endtask

  // Monitor: pops the expected result whenever the DUT presents one.
  always @(negedge clk) begin
    if (reset_n) begin
      while (disp_q.size() > 0 && disp_q[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL disp_missing: got none expected %0h due %0d", disp_q[0].data, disp_q[0].due);
        void'(disp_q.pop_front());
      end
      while (cpu_q.size() > 0 && cpu_q[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL cpu_missing: got none expected %0h due %0d", cpu_q[0].data, cpu_q[0].due);
        void'(cpu_q.pop_front());
      end
      if (bus.disp_valid) begin
        if (disp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL disp_unexpected: got %0h expected no result", bus.disp_data);
        end else begin
          e_mon = disp_q.pop_front();
          chk("disp_latency", cyc, e_mon.due);
          chk("disp_data", bus.disp_data, e_mon.data);
        end
      end
      if (bus.cpu_rvalid) begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_unexpected: got %0h expected no result", bus.cpu_rdata);
        end else begin
          e_mon = cpu_q.pop_front();
          chk("cpu_latency", cyc, e_mon.due);
          chk("cpu_rdata", bus.cpu_rdata, e_mon.data);
        end
      end
    end
  end

  initial begin
    stim_t s, hold;
    bit pend;
    int busy_cnt, wr_cnt;
    bit cpu_done;
    for (int a = 0; a < 2048; a++) mem[a] = 8'h00;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLUMNS; c++) screen[r][c] = 8'h00;
    do_reset();

    // CPU write then read back at row 0, col 5.
    s = idle_stim(); s.cv = 1; s.cwe = 1; s.crow = 0; s.ccol = 5; s.cwd = 8'h41;
    step(s);
    s.cwe = 0; step(s);
    step(idle_stim());

    // Display fetch stalls a held CPU read for one cycle.
    s = idle_stim(); s.cv = 1; s.crow = 0; s.ccol = 5; s.dreq = 1; s.drow = 1; s.dcol = 0;
    step(s);
    s.dreq = 0; step(s);
    step(idle_stim());

    // Scroll wrap.
    for (int i = 0; i < 23; i++) begin
      s = idle_stim(); s.sinc = 1; step(s);
      for (int w = 0; w < 200 && m_busy; w++) step(idle_stim());
    end
    chk("scroll_23", bus.scroll_row, 23);
    s = idle_stim(); s.cv = 1; s.cwe = 1; s.crow = 1; s.ccol = 0; s.cwd = 8'h7E;
    step(s);
    s = idle_stim(); s.sinc = 1; step(s);
    for (int w = 0; w < 200 && m_busy; w++) step(idle_stim());
    chk("scroll_wrap0", bus.scroll_row, 0);

    // Out-of-range display fetches (back-to-back) and CPU accesses.
    s = idle_stim(); s.dreq = 1; s.drow = 24; s.dcol = 80; step(s);
    s.drow = 0; step(s);
    s.drow = 24; s.dcol = 0; step(s);
    s = idle_stim(); s.cv = 1; s.cwe = 1; s.crow = 24; s.ccol = 3; s.cwd = 8'hAA; step(s);
    s.cwe = 0; s.crow = 2; s.ccol = 90; step(s);
    s.crow = 1; s.ccol = 0; step(s);
    step(idle_stim());

`ifdef VRAM_FILL_EN
    // Fill row 2 with display interruptions; CPU read held throughout.
    do_reset();
    s = idle_stim(); s.fstart = 1; s.frow = 2; step(s);
    busy_cnt = 0; wr_cnt = 0; cpu_done = 0;
    for (int k = 0; k < 110; k++) begin
      s = idle_stim();
      s.dreq = (k == 10 || k == 40); s.drow = 0; s.dcol = 7'(k % 80);
      if (k == 20) begin s.fstart = 1; s.frow = 5; end
      if (!cpu_done) begin s.cv = 1; s.crow = 3; s.ccol = 3; end
      step(s);
      if (smp_busy) busy_cnt++;
      if (smp_we) wr_cnt++;
      if (last_ready) cpu_done = 1;
    end
    chk("fill_busy_cycles", busy_cnt, 82);
    chk("fill_write_count", wr_cnt, 80);
    chk("fill_cpu_done", cpu_done, 1);

    // Scroll-triggered fill of the exposed bottom line, then reset mid-fill.
    do_reset();
    s = idle_stim(); s.sinc = 1; step(s);
    chk("scroll_fill_row", bus.scroll_row, 1);
    wr_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step(idle_stim());
      if (smp_we) wr_cnt++;
    end
    chk("scroll_fill_writes", wr_cnt, 80);
    s = idle_stim(); s.sinc = 1; step(s);
    for (int k = 0; k < 30; k++) step(idle_stim());
    reset_n = 1'b0;
    #1;
    chk("midfill_rst_we", bus.ram_we, 0);
    chk("midfill_rst_busy", bus.fill_busy, 0);
    m_scroll = 0; m_busy = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) step(idle_stim());
`endif

    // Randomized traffic.
    pend = 0;
    hold = idle_stim();
    for (int i = 0; i < 600; i++) begin
      s = idle_stim();
      s.dreq = ($urandom_range(0, 2) == 0);
      s.drow = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      s.dcol = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(80, 127)) : 7'($urandom_range(0, 79));
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1;
        hold.cwe  = 1'($urandom_range(0, 1));
        hold.crow = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 3));
        hold.ccol = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(80, 127)) : 7'($urandom_range(0, 7));
        hold.cwd  = 8'($urandom_range(0, 255));
      end
      if (pend) begin
        s.cv = 1; s.cwe = hold.cwe; s.crow = hold.crow; s.ccol = hold.ccol; s.cwd = hold.cwd;
      end
      s.sinc = ($urandom_range(0, 15) == 0);
`ifdef VRAM_FILL_EN
      s.fstart = !s.sinc && ($urandom_range(0, 39) == 0);
      s.frow   = 5'($urandom_range(0, 31));
`endif
      step(s);
      if (last_ready) pend = 0;
    end

    for (int k = 0; k < 3; k++) step(idle_stim());
    chk("disp_queue_drained", disp_q.size(), 0);
    chk("cpu_queue_drained", cpu_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
